// File: rtl/weight_buf_reader_pkg.sv
// Shared definitions for the weight-buffer read path: FSM encoding, default
// buffer geometry and the in-flight read tag carried alongside the RAM latency.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } wb_state_t;

  localparam int unsigned DEF_RD_LAT     = 2;
  localparam int unsigned DEF_BUF_ADDR_W = 15;
  localparam int unsigned DEF_WIDTH      = 128;

  typedef struct packed {
    logic vld;
    logic last;
  } rd_tag_t;

  // Bits needed to hold an occupancy value in 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/weight_buf_reader_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; holds the
// read data plus its last tag while the stream consumer applies backpressure.
module weight_stream_fifo #(
  parameter int unsigned WIDTH = 129,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count != FULL_CNT);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/weight_buf_reader.sv
// Streams a base/length run of words from the weight buffer onto a valid/ready
// stream, issuing reads only while FIFO space covers every read in flight.
module weight_buf_reader
  import wb_pkg::*;
#(
  parameter int unsigned BUF_ADDR_W = DEF_BUF_ADDR_W,
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned RD_LAT     = DEF_RD_LAT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clka,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [BUF_ADDR_W-1:0] cmd_base,
  input  logic [BUF_ADDR_W:0]   cmd_len,
  output logic                  buf_ena,
  output logic [BUF_ADDR_W-1:0] buf_addr,
  input  logic [WIDTH-1:0]      buf_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [BUF_ADDR_W:0] LEN_ONE = (BUF_ADDR_W + 1)'(1);

  wb_state_t             state_q, state_d;
  logic [BUF_ADDR_W-1:0] addr_q;
  logic [BUF_ADDR_W:0]   rem_q;
  rd_tag_t               pipe_q [RD_LAT];
  logic [CNT_W-1:0]      inflight, fifo_count;
  logic [WIDTH:0]        fifo_dout;
  logic                  accept, issue, issue_last, credit_ok;
  logic                  push, pop, zero_done_q, last_seen_q, drain_done;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CNT_W'(pipe_q[i].vld);
    end
  end

  // Every outstanding read already owns a FIFO slot, so the push never overflows.
  assign credit_ok  = ({1'b0, fifo_count} + {1'b0, inflight}) < CREDIT_MAX;
  assign push       = pipe_q[RD_LAT-1].vld;
  assign m_valid    = (fifo_count != '0);
  assign pop        = m_valid && m_ready;
  assign issue_last = issue && (rem_q == LEN_ONE);
  assign drain_done = (state_q == DRAIN) && last_seen_q && (inflight == '0) && !m_valid;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_len != '0) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (rem_q == LEN_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      zero_done_q <= 1'b0;
      last_seen_q <= 1'b0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      zero_done_q <= accept && (cmd_len == '0);
      if (accept) begin
        addr_q      <= cmd_base;
        rem_q       <= cmd_len;
        last_seen_q <= 1'b0;
      end else begin
        if (issue) begin
          addr_q <= addr_q + 1'b1;
          rem_q  <= rem_q - 1'b1;
        end
        if (pop && m_last) last_seen_q <= 1'b1;
      end
      pipe_q[0].vld  <= issue;
      pipe_q[0].last <= issue_last;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  weight_stream_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clka),
    .rst_n (rst_n),
    .push  (push),
    .din   ({pipe_q[RD_LAT-1].last, buf_dout}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign {m_last, m_data} = fifo_dout;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign buf_ena   = issue;
  assign buf_addr  = addr_q;
  assign done      = zero_done_q | drain_done;

endmodule

// File: tb/tb_weight_buf_reader.sv
// Directed and randomized checks of weight_buf_reader against a RAM model and
// an expected-beat queue built from the buffer contents.
module tb_weight_buf_reader;

  localparam int AW    = 15;
  localparam int W     = 128;
  localparam int DEPTH = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic          clka = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base = '0;
  logic [AW:0]   cmd_len = '0;
  logic          buf_ena;
  logic [AW-1:0] buf_addr;
  logic [W-1:0]  buf_dout;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc = 0;

  logic ready_fixed = 1'b1;
  logic rand_mode = 1'b0;

  logic [W-1:0] ram [0:(1<<AW)-1];
  logic [W-1:0] rd1, rd2;
  logic         en1;

  beat_t exp_q[$];
  int ena_cyc[$];
  int ena_addr[$];
  int beat_cyc[$];
  int beat_last[$];
  int done_cyc[$];
  int valid_cnt, rdy_low_cnt, last_cnt, issued, accepted;
  logic prev_stall;
  logic [W-1:0] prev_data;
  logic prev_last;

  weight_buf_reader #(
    .BUF_ADDR_W (AW),
    .WIDTH      (W),
    .RD_LAT     (2),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clka      (clka),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
    .buf_ena   (buf_ena),
    .buf_addr  (buf_addr),
    .buf_dout  (buf_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clka = ~clka;

  always @(posedge clka) cyc++;

  // Two-cycle registered-read buffer model.
  always @(posedge clka) begin
    if (buf_ena) rd1 <= ram[buf_addr];
    en1 <= buf_ena;
    if (en1) rd2 <= rd1;
  end
  assign buf_dout = rd2;

  always begin
    @(posedge clka);
    #2;
    m_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clka) begin
    beat_t e;
    if (!rst_n) begin
      issued = 0;
      accepted = 0;
      prev_stall = 1'b0;
    end else begin
      if (!cmd_ready) rdy_low_cnt++;
      if (m_valid) valid_cnt++;
      if (done) done_cyc.push_back(cyc);
      if (buf_ena) begin
        issued++;
        ena_cyc.push_back(cyc);
        ena_addr.push_back(int'(buf_addr));
        check_i("outstanding_le_depth", int'(issued - accepted <= DEPTH), 1);
      end
      if (prev_stall) begin
        check_i("stall_valid", int'(m_valid), 1);
        check("stall_data", m_data, prev_data);
        check_i("stall_last", int'(m_last), int'(prev_last));
      end
      if (m_valid && m_ready) begin
        accepted++;
        beat_cyc.push_back(cyc);
        beat_last.push_back(int'(m_last));
        if (m_last) last_cnt++;
        check_i("beat_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("beat_data", m_data, e.d);
          check_i("beat_last", int'(m_last), int'(e.l));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic clear_logs();
    ena_cyc.delete();
    ena_addr.delete();
    beat_cyc.delete();
    beat_last.delete();
    done_cyc.delete();
    valid_cnt = 0;
    rdy_low_cnt = 0;
    last_cnt = 0;
  endtask

  task automatic send_cmd(input logic [AW-1:0] b, input logic [AW:0] l);
    int t = 0;
    logic rdy = 1'b0;
    beat_t e;
    logic [AW-1:0] a;
    cmd_base = b;
    cmd_len = l;
    cmd_valid = 1'b1;
    while (!rdy && t < 3000) begin
      @(negedge clka);
      rdy = cmd_ready;
      acc = cyc;
      @(posedge clka);
      t++;
    end
    #1 cmd_valid = 1'b0;
    check_i("cmd_accept_timeout", int'(rdy), 1);
    a = b;
    for (int i = 0; i < int'(l); i++) begin
      e.d = ram[a];
      e.l = (i == int'(l) - 1);
      exp_q.push_back(e);
      a = a + 15'd1;
    end
  endtask

  task automatic wait_done(input int n, input int bound);
    int t = 0;
    while (done_cyc.size() < n && t < bound) begin
      @(posedge clka);
      #1;
      t++;
    end
    check_i("done_timeout", int'(done_cyc.size() >= n), 1);
    repeat (2) begin
      @(posedge clka);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_i({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    check_i({tag, "_buf_ena"}, int'(buf_ena), 0);
    check_i({tag, "_buf_addr"}, int'(buf_addr), 0);
    check_i({tag, "_m_valid"}, int'(m_valid), 0);
    check({tag, "_m_data"}, m_data, '0);
    check_i({tag, "_m_last"}, int'(m_last), 0);
    check_i({tag, "_busy"}, int'(busy), 0);
    check_i({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int n_early;
    int wrap_a[4];
    wrap_a = '{32'h7FFE, 32'h7FFF, 32'h0000, 32'h0001};
    for (int i = 0; i < (1 << AW); i++) ram[i] = {$urandom, $urandom, $urandom, $urandom};

    // Power-on reset.
    repeat (2) @(posedge clka);
    @(negedge clka);
    check_reset_vals("rst0");
    @(posedge clka);
    #1 rst_n = 1'b1;
    @(posedge clka);
    #1;

    // Basic 4-word command with consumer always ready.
    clear_logs();
    send_cmd(15'h0010, 16'd4);
    wait_done(1, 100);
    check_i("t1_ena_cnt", ena_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_i("t1_addr", ena_addr[i], 16 + i);
      check_i("t1_ena_cyc", ena_cyc[i], acc + 1 + i);
      check_i("t1_beat_cyc", beat_cyc[i], acc + 4 + i);
      check_i("t1_beat_last", beat_last[i], int'(i == 3));
    end
    check_i("t1_beat_cnt", beat_cyc.size(), 4);
    check_i("t1_done_cyc", done_cyc[0], acc + 8);
    check_i("t1_rdy_low_cycles", rdy_low_cnt, 8);

    // Backpressure: consumer stalls for cycles 3..14 of a 16-word command.
    clear_logs();
    send_cmd(15'h0400, 16'd16);
    for (int k = 1; k <= 80 && done_cyc.size() == 0; k++) begin
      ready_fixed = !(k >= 3 && k <= 14);
      @(posedge clka);
      #1;
    end
    ready_fixed = 1'b1;
    wait_done(1, 100);
    n_early = 0;
    foreach (ena_cyc[i]) if (ena_cyc[i] <= acc + 14) n_early++;
    check_i("t2_issues_during_stall", n_early, DEPTH);
    check_i("t2_resume_cyc", ena_cyc[4], acc + 16);
    check_i("t2_ena_cnt", ena_cyc.size(), 16);
    for (int i = 0; i < 16; i++) check_i("t2_addr", ena_addr[i], 32'h400 + i);
    check_i("t2_beat_cnt", beat_cyc.size(), 16);
    check_i("t2_exp_empty", exp_q.size(), 0);

    // Address wrap at the top of the buffer.
    clear_logs();
    send_cmd(15'h7FFE, 16'd4);
    wait_done(1, 100);
    for (int i = 0; i < 4; i++) begin
      check_i("t3_addr", ena_addr[i], wrap_a[i]);
      check_i("t3_beat_last", beat_last[i], int'(i == 3));
    end
    check_i("t3_last_cnt", last_cnt, 1);

    // Zero-length command.
    clear_logs();
    send_cmd(15'h0123, 16'd0);
    @(negedge clka);
    check_i("t4_done_pulse", int'(done), 1);
    @(posedge clka);
    #1;
    @(negedge clka);
    check_i("t4_cmd_ready_back", int'(cmd_ready), 1);
    check_i("t4_done_clear", int'(done), 0);
    repeat (3) @(posedge clka);
    #1;
    check_i("t4_no_ena", ena_cyc.size(), 0);
    check_i("t4_no_valid", valid_cnt, 0);
    check_i("t4_done_cnt", done_cyc.size(), 1);
    check_i("t4_done_cyc", done_cyc[0], acc + 1);

    // One-cycle reset in the middle of a 16-word burst.
    clear_logs();
    send_cmd(15'h0100, 16'd16);
    repeat (5) begin
      @(posedge clka);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clka);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clka);
    check_reset_vals("t5_rst");
    @(posedge clka);
    #1;
    clear_logs();
    send_cmd(15'h0200, 16'd2);
    wait_done(1, 100);
    check_i("t5_ena_cnt", ena_cyc.size(), 2);
    check_i("t5_beat_cnt", beat_cyc.size(), 2);
    check_i("t5_exp_empty", exp_q.size(), 0);
    check_i("t5_last_cnt", last_cnt, 1);

    // Random commands under 50% consumer readiness.
    clear_logs();
    rand_mode = 1'b1;
    for (int n = 0; n < 100; n++) begin
      send_cmd(15'($urandom_range(0, 32767)), 16'($urandom_range(1, 24)));
    end
    wait_done(100, 20000);
    rand_mode = 1'b0;
    check_i("t6_exp_empty", exp_q.size(), 0);
    check_i("t6_last_cnt", last_cnt, 100);
    check_i("t6_done_cnt", done_cyc.size(), 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_buf_reader.md
# weight_buf_reader

Streams a contiguous run of words out of the unified weight buffer (simple-dual-port block RAM, 2-cycle registered read) and presents them as a valid/ready stream to the compute array's weight loader. It accepts a base/length command, drives the buffer's read port, tracks in-flight reads through the RAM latency, and absorbs downstream backpressure in a small credit-limited FIFO so that no read data is dropped.

## Interface
- BUF_ADDR_W, 15, buffer word-address width
- WIDTH, 128, word width in bits
- RD_LAT, 2, buffer read latency in cycles, from buf_ena/buf_addr to buf_dout
- FIFO_DEPTH, 4, output FIFO entries; must be ≥ RD_LAT+2 for full throughput

Ports:
- clka  in  1  sole clock; the buffer runs on the same clock
- rst_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_base  in  BUF_ADDR_W  first word address
- cmd_len  in  BUF_ADDR_W+1  word count, 0..2^BUF_ADDR_W
- buf_ena  out  1  buffer read enable
- buf_addr  out  BUF_ADDR_W  buffer read address
- buf_dout  in  WIDTH  buffer read data, valid RD_LAT cycles after buf_ena
- m_valid  out  1  stream data valid
- m_ready  in  1  stream consumer ready
- m_data  out  WIDTH  stream data
- m_last  out  1  marks the final word of a command
- busy  out  1  high in ISSUE or DRAIN
- done  out  1  one-cycle pulse at command completion

## Operation
- States are IDLE, ISSUE and DRAIN.
- IDLE:
  - cmd_ready=1.
  - If cmd_valid and cmd_len≠0: latch base into the address counter and len into the remaining counter, then go to ISSUE.
  - If cmd_valid and cmd_len=0: accept the command, pulse done the next cycle, stay in IDLE, and issue no buf_ena.
- ISSUE:
  - Issue one read per cycle when credit is available: fifo_count + inflight < FIFO_DEPTH, using registered counts.
  - On each issue: buf_ena=1, buf_addr=addr counter; the address counter increments modulo 2^BUF_ADDR_W (wraps from all-ones to 0) and remaining decrements.
  - The read that takes remaining to 0 is tagged last; after it, go to DRAIN.
- In-flight tracking:
  - An RD_LAT-deep shift register carries {valid, last}.
  - At its output, buf_dout and the last tag are pushed into the FIFO. Credit guarantees the FIFO is never full at push time.
- DRAIN: once inflight=0, the FIFO is empty and the last beat has been accepted (m_valid & m_ready & m_last), pulse done and return to IDLE.
- Output stream:
  - m_valid = FIFO non-empty; m_data and m_last come from the FIFO head.
  - A beat transfers on m_valid & m_ready.
  - m_data and m_last hold stable while m_valid=1 and m_ready=0.
- A FIFO push and pop in the same cycle leaves fifo_count unchanged.
- buf_ena is never asserted outside ISSUE.
- Reset, including mid-operation:
  - All state returns to IDLE and both counters clear.
  - The in-flight pipe and the FIFO are flushed; RAM data returning after reset is discarded.
  - Reset values: cmd_ready=1, buf_ena=0, buf_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0.

## Timing
- Cycle 0: command handshake.
- Cycle 1: first buf_ena.
- Cycle 1+RD_LAT: buf_dout valid; pushed into the FIFO at the end of that cycle.
- Cycle 2+RD_LAT (cycle 4 with defaults): first m_valid.
- With m_ready held high: one word per cycle, and done occurs one cycle after the last beat is accepted.
- When m_ready is low: at most FIFO_DEPTH words are outstanding (FIFO plus in flight). buf_ena deasserts within one cycle of credit exhaustion and resumes the cycle after credit frees.
- cmd_ready=0 from the cycle after acceptance until the cycle after done.

## Structure
- Shared package wb_pkg holds:
  - the state encoding (IDLE=0, ISSUE=1, DRAIN=2)
  - the default RD_LAT, BUF_ADDR_W and WIDTH constants, shared with the buffer wrapper
- Sub-module weight_stream_fifo: a synchronous FIFO of width WIDTH+1 (data plus last), depth FIFO_DEPTH, with a count output, first-word-fall-through, and synchronous active-low reset.
- Credit logic, the in-flight pipe and the FSM live in the top module.

## Test plan
- cmd_base=0x0010, cmd_len=4, m_ready=1 → buf_addr 0x10,0x11,0x12,0x13 on cycles 1-4; m_valid cycles 4-7 with matching data; m_last on cycle 7; done on cycle 8.
- cmd_len=16, m_ready low for cycles 3-14 → buf_ena stops once 4 words are outstanding; no words are lost or duplicated; the full 16-word sequence arrives in order after m_ready rises.
- cmd_base=0x7FFE, cmd_len=4 → buf_addr 0x7FFE,0x7FFF,0x0000,0x0001; m_last on the 4th beat.
- cmd_len=0 → done one cycle after acceptance; buf_ena and m_valid never assert; cmd_ready is back to 1 the following cycle.
- rst_n low for one cycle in the middle of a 16-word burst → all outputs at reset values next cycle; in-flight RAM data is discarded; a new 2-word command then completes correctly.
- Random m_ready, 50% duty, over 100 random commands → scoreboard matches buffer contents, m_last counts equal command count, and done pulses equal command count.
